b_fifo_ctrl: RTL and testbench

Pointer, occupancy and handshake controller that sequences the dual-port B_SRAM buffer (288-bit words, 4 entries) as a circular FIFO. It sits between an upstream producer and a downstream consumer, both valid/ready. It drives B_SRAM's write and read ports and hides the RAM's one-cycle registered read and read-before-write hazard from both sides.

---
 rtl/b_fifo_pkg.sv | 31 +++
 rtl/b_fifo_ctrl_if.sv | 43 ++++
 rtl/b_fifo_ptr.sv | 35 +++
 rtl/b_fifo_ctrl.sv | 131 +++++++++++++
 tb/tb_b_fifo_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/b_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : b_fifo_pkg
// Description : Shared constants, state encoding and pointer helper for the
//               B_SRAM FIFO controller (4 x 288-bit circular buffer).
// Revision    : 1.0  initial release
// ============================================================================
package b_fifo_pkg;

    localparam int ADR_W  = 2;
    localparam int DATA_W = 288;
    localparam int DEPTH  = 2 ** ADR_W;
    localparam int LVL_W  = ADR_W + 1;

    localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_ALMOST = LVL_W'(DEPTH - 1);

    // Occupancy class derived from level
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } fifo_state_t;

    // Wrapping increment: natural overflow of the ADR_W-bit sum gives 3 -> 0
    function automatic logic [ADR_W-1:0] ptr_next(input logic [ADR_W-1:0] p);
        return p + ADR_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/b_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : b_fifo_ctrl_if
// Description : Producer/consumer handshake, B_SRAM port and occupancy bundle
//               of the FIFO controller.
//               slave  : controller side (b_fifo_ctrl)
//               master : environment side (producer, consumer, B_SRAM)
// Revision    : 1.0  initial release
// ============================================================================
interface b_fifo_ctrl_if;
    import b_fifo_pkg::*;

    // producer side
    logic                in_valid;
    logic [DATA_W-1:0]   in_data;
    logic                in_ready;
    // consumer side
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic                out_ready;
    // B_SRAM ports
    logic                sram_wr_en;
    logic [ADR_W-1:0]    sram_wr_adr;
    logic [DATA_W-1:0]   sram_wr_dt;
    logic [ADR_W-1:0]    sram_rd_adr;
    logic [DATA_W-1:0]   sram_rd_dto;
    // status
    logic [LVL_W-1:0]    level;

    modport slave (
        input  in_valid, in_data, out_ready, sram_rd_dto,
        output in_ready, out_valid, out_data,
               sram_wr_en, sram_wr_adr, sram_wr_dt, sram_rd_adr, level
    );

    modport master (
        output in_valid, in_data, out_ready, sram_rd_dto,
        input  in_ready, out_valid, out_data,
               sram_wr_en, sram_wr_adr, sram_wr_dt, sram_rd_adr, level
    );

endinterface
`default_nettype wire

// File: rtl/b_fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : b_fifo_ptr
// Description : ADR_W-bit wrapping FIFO pointer.
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset
//   clr  in   synchronous clear (flush), same effect as rst
//   inc  in   advance pointer by one, modulo DEPTH
//   ptr  out  current pointer value
// Revision    : 1.0  initial release
// ============================================================================
module b_fifo_ptr
    import b_fifo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [ADR_W-1:0] ptr
);

    logic [ADR_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= ptr_next(r_ptr);
        end
    end

    assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/b_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : b_fifo_ctrl
// Description : Pointer/occupancy/handshake controller running B_SRAM as a
//               4-entry circular FIFO. Hides the RAM's registered read and
//               read-before-write hazard from producer and consumer.
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   flush      in   synchronous clear of all FIFO state (RAM untouched)
//   bus        --   b_fifo_ctrl_if.slave: in_valid/in_data/in_ready,
//                   out_valid/out_data/out_ready, sram_* ports, level
//   max_level  out  peak level since reset/flush (B_FIFO_WATERMARK_EN only)
// Build option: define B_FIFO_WATERMARK_EN to add the max_level watermark.
// Revision    : 1.0  initial release
// ============================================================================
module b_fifo_ctrl
    import b_fifo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    b_fifo_ctrl_if.slave     bus
`ifdef B_FIFO_WATERMARK_EN
    ,
    output logic [LVL_W-1:0] max_level
`endif
);

    fifo_state_t       r_state;
    logic [LVL_W-1:0]  r_level;
    logic              r_fresh;

    logic              w_clr;
    logic              w_push;
    logic              w_pop;
    logic [ADR_W-1:0]  w_wr_ptr;
    logic [ADR_W-1:0]  w_rd_ptr;
    logic [ADR_W-1:0]  w_rd_adr;

    // A transfer coinciding with reset/flush is discarded, so it must not
    // move pointers nor strobe the RAM.
    assign w_clr  = rst | flush;

    // Handshake flags come only from registered state, never from the
    // opposite side's valid/ready.
    assign bus.in_ready  = (r_state != ST_FULL);
    assign bus.out_valid = (r_state != ST_EMPTY) && !r_fresh;

    assign w_push = bus.in_valid  & bus.in_ready  & ~w_clr;
    assign w_pop  = bus.out_valid & bus.out_ready & ~w_clr;

    b_fifo_ptr u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (w_push),
        .ptr (w_wr_ptr)
    );

    b_fifo_ptr u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (w_pop),
        .ptr (w_rd_ptr)
    );

    // Look one entry ahead on pop so the registered read already holds the
    // new head when the pop completes.
    assign w_rd_adr = w_pop ? ptr_next(w_rd_ptr) : w_rd_ptr;

    assign bus.sram_wr_en  = w_push;
    assign bus.sram_wr_adr = w_wr_ptr;
    assign bus.sram_wr_dt  = bus.in_data;
    assign bus.sram_rd_adr = w_rd_adr;
    assign bus.out_data    = bus.sram_rd_dto;
    assign bus.level       = r_level;

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state <= ST_EMPTY;
            r_level <= '0;
            r_fresh <= 1'b0;
        end else begin
            r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
            // Reading the slot being written returns stale data; hold
            // out_valid low for one cycle until the re-read lands.
            r_fresh <= w_push && (w_wr_ptr == w_rd_adr);

            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_state <= ST_PARTIAL;
                    end
                end
                ST_PARTIAL: begin
                    if (w_push && !w_pop && (r_level == LVL_ALMOST)) begin
                        r_state <= ST_FULL;
                    end else if (w_pop && !w_push && (r_level == LVL_ONE)) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_state <= ST_PARTIAL;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

`ifdef B_FIFO_WATERMARK_EN
    logic [LVL_W-1:0] r_max_level;

    // Tracks the registered level, so the peak appears one edge after it.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_max_level <= '0;
        end else if (r_level > r_max_level) begin
            r_max_level <= r_level;
        end
    end

    assign max_level = r_max_level;
`endif

endmodule
`default_nettype wire

// File: tb/tb_b_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_b_fifo_ctrl
// Description : Self-checking bench for b_fifo_ctrl with a behavioural
//               B_SRAM (registered, read-before-write) beside it.
//               Define B_FIFO_WATERMARK_EN to also check max_level.
// Revision    : 1.0  initial release
// ============================================================================
module tb_b_fifo_ctrl;
    import b_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
`ifdef B_FIFO_WATERMARK_EN
    logic [LVL_W-1:0] max_level;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    b_fifo_ctrl_if bus ();

    b_fifo_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus)
`ifdef B_FIFO_WATERMARK_EN
        ,
        .max_level (max_level)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // B_SRAM model: nonblocking update gives pre-write data on same address
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.sram_wr_en) mem[bus.sram_wr_adr] <= bus.sram_wr_dt;
        bus.sram_rd_dto <= mem[bus.sram_rd_adr];
    end

    typedef struct {
        logic        iv;
        logic [15:0] din;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [2:0]  e_lvl;
        logic        chk_d;
        logic [15:0] e_d;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic iv, input logic [15:0] din,
                                input logic ordy, input logic e_ir,
                                input logic e_ov, input logic [2:0] e_lvl,
                                input logic chk_d, input logic [15:0] e_d);
        vec_t v;
        v.iv = iv; v.din = din; v.ordy = ordy; v.e_ir = e_ir;
        v.e_ov = e_ov; v.e_lvl = e_lvl; v.chk_d = chk_d; v.e_d = e_d;
        return v;
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [15:0] d, input logic ordy);
        bus.in_valid  = iv;
        bus.in_data   = DATA_W'(d);
        bus.out_ready = ordy;
    endtask

    initial begin
        int sent, rcv, first_rx, last_rx;

        // fill, full-no-passthrough, drain, hazard cases
        vecs[0]  = mk(1'b1, 16'hA, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0);
        vecs[1]  = mk(1'b1, 16'hB, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 16'h0);
        vecs[2]  = mk(1'b1, 16'hC, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 16'hA);
        vecs[3]  = mk(1'b1, 16'hD, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 16'hA);
        vecs[4]  = mk(1'b1, 16'hE, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 16'hA);
        vecs[5]  = mk(1'b1, 16'hE, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 16'hA);
        vecs[6]  = mk(1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 16'hB);
        vecs[7]  = mk(1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 16'hC);
        vecs[8]  = mk(1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 16'hD);
        vecs[9]  = mk(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0);
        vecs[10] = mk(1'b1, 16'h1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0);
        vecs[11] = mk(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 16'h0);
        vecs[12] = mk(1'b1, 16'h2, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 16'h1);
        vecs[13] = mk(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 16'h0);
        vecs[14] = mk(1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 16'h2);
        vecs[15] = mk(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0);

        drive(1'b0, 16'h0, 1'b0);

        // ---- reset ----
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst in_ready",    DATA_W'(bus.in_ready),    DATA_W'(1));
        check("rst out_valid",   DATA_W'(bus.out_valid),   DATA_W'(0));
        check("rst level",       DATA_W'(bus.level),       DATA_W'(0));
        check("rst sram_wr_en",  DATA_W'(bus.sram_wr_en),  DATA_W'(0));
        check("rst sram_wr_adr", DATA_W'(bus.sram_wr_adr), DATA_W'(0));
        check("rst sram_rd_adr", DATA_W'(bus.sram_rd_adr), DATA_W'(0));

        // ---- table-driven vectors ----
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].din, vecs[i].ordy);
            #1;
            check($sformatf("row%0d in_ready", i),  DATA_W'(bus.in_ready),  DATA_W'(vecs[i].e_ir));
            check($sformatf("row%0d out_valid", i), DATA_W'(bus.out_valid), DATA_W'(vecs[i].e_ov));
            check($sformatf("row%0d level", i),     DATA_W'(bus.level),     DATA_W'(vecs[i].e_lvl));
            if (vecs[i].chk_d)
                check($sformatf("row%0d out_data", i), bus.out_data, DATA_W'(vecs[i].e_d));
        end

        // ---- streaming across pointer wrap ----
        sent = 0; rcv = 0; first_rx = -1; last_rx = -1;
        for (int c = 0; c < 60 && rcv < 10; c++) begin
            @(negedge clk);
            drive(sent < 10, 16'h10 + 16'(sent), 1'b1);
            #1;
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.out_valid) begin
                check($sformatf("stream word%0d", rcv), bus.out_data, DATA_W'(16'h10 + 16'(rcv)));
                if (first_rx < 0) first_rx = cyc;
                last_rx = cyc;
                rcv++;
            end
            if (first_rx >= 0 && sent < 10 && bus.in_valid)
                check("stream level", DATA_W'(bus.level), DATA_W'(2));
        end
        check("stream count", DATA_W'(rcv), DATA_W'(10));
        check("stream span",  DATA_W'(last_rx - first_rx), DATA_W'(9));

        // ---- flush at level 3 with a concurrent push ----
        @(negedge clk);
        drive(1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 16'h21 + 16'(k), 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 16'h0, 1'b0);
        #1;
        check("pre-flush level", DATA_W'(bus.level), DATA_W'(3));
        @(negedge clk);
        drive(1'b1, 16'h99, 1'b1);
        flush = 1'b1;
        #1;
`ifdef B_FIFO_WATERMARK_EN
        check("pre-flush max_level", DATA_W'(max_level), DATA_W'(3));
`endif
        @(negedge clk);
        flush = 1'b0;
        drive(1'b1, 16'h30, 1'b0);
        #1;
        check("flush level",     DATA_W'(bus.level),       DATA_W'(0));
        check("flush out_valid", DATA_W'(bus.out_valid),   DATA_W'(0));
        check("flush in_ready",  DATA_W'(bus.in_ready),    DATA_W'(1));
        check("flush wr_adr",    DATA_W'(bus.sram_wr_adr), DATA_W'(0));
`ifdef B_FIFO_WATERMARK_EN
        check("flush max_level", DATA_W'(max_level), DATA_W'(0));
`endif
        @(negedge clk);
        drive(1'b0, 16'h0, 1'b0);
        #1;
        check("post-flush hazard out_valid", DATA_W'(bus.out_valid), DATA_W'(0));
        @(negedge clk);
        #1;
        check("post-flush out_valid", DATA_W'(bus.out_valid), DATA_W'(1));
        check("post-flush out_data",  bus.out_data, DATA_W'(16'h30));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
